w_ptr_ctrl: RTL and testbench

Parametrised write-side pointer controller for the asynchronous FIFO, supporting any depth ≥ 2, including non-power-of-two depths, via offset Gray coding. It sits in the `wclk` domain between the write port and the FIFO RAM. It consumes the synchronised Gray read pointer and produces:
- the RAM write address,
- binary and Gray write pointers,
- registered full and almost-full flags,
- a fill level,
- a sticky overflow flag.

All `DEPTH` slots are usable; none is reserved.

---
 rtl/fifo_ptr_pkg.sv | 35 +++
 rtl/gray2bin_conv.sv | 13 +
 rtl/w_ptr_ctrl.sv | 104 ++++++++++
 tb/tb_w_ptr_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ptr_pkg.sv
// Pointer helpers shared by the write- and read-side controllers of the asynchronous FIFO.
// Gray conversions work on a 32-bit container; callers cast to their own pointer width.
package fifo_ptr_pkg;

  function automatic int ptr_width(input int depth);
    return $clog2(2 * depth);
  endfunction

  function automatic int addr_width(input int depth);
    return ($clog2(depth) > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Centring the 2*depth codes in the code space makes the wrap a single MSB flip in Gray.
  function automatic int ptr_offset(input int depth, input int pw);
    return ((1 << pw) - 2 * depth) / 2;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int s = 1; s < 32; s = s << 1) begin
      b = b ^ (b >> s);
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary decoder of parametric width.
module gray2bin_conv #(
  parameter int W = 4
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin[i] = ^gray[W-1:i];
  end

endmodule

// File: rtl/w_ptr_ctrl.sv
// Write-side pointer controller for the asynchronous FIFO; offset Gray coding lets any depth >= 2
// use every slot while keeping the Gray pointer a one-bit-per-cycle signal.
module w_ptr_ctrl
  import fifo_ptr_pkg::*;
#(
  parameter int DEPTH = 45,
  parameter int PW    = ptr_width(DEPTH),
  parameter int AW    = addr_width(DEPTH),
  parameter int LW    = level_width(DEPTH)
) (
  input  logic          wclk,
  input  logic          wrst_n,
  input  logic          wen,
  input  logic [PW-1:0] g_rptr_sync,
  input  logic [LW-1:0] afull_thresh,
  input  logic          clr_ovf,
  output logic [AW-1:0] waddr,
  output logic [PW-1:0] b_wptr,
  output logic [PW-1:0] g_wptr,
  output logic [LW-1:0] wlevel,
  output logic          full,
  output logic          almost_full,
  output logic          overflow
);

  localparam int            OFFSET     = ptr_offset(DEPTH, PW);
  localparam logic [PW-1:0] FIRST      = PW'(OFFSET);
  localparam logic [PW-1:0] LAST       = PW'(OFFSET + 2 * DEPTH - 1);
  localparam logic [PW-1:0] FIRST_GRAY = PW'(bin2gray(32'(OFFSET)));
  localparam logic [AW-1:0] ADDR_LAST  = AW'(DEPTH - 1);
  localparam logic [PW:0]   SPAN       = (PW + 1)'(2 * DEPTH);
  localparam logic [LW-1:0] LVL_FULL   = LW'(DEPTH);

  logic          accept;
  logic [PW-1:0] b_rptr;
  logic [PW-1:0] next_b_wptr;
  logic [AW-1:0] next_waddr;
  logic [PW:0]   diff;
  logic [PW:0]   level_wide;
  logic [LW-1:0] wlevel_next;

  gray2bin_conv #(.W(PW)) u_rptr_dec (
    .gray (g_rptr_sync),
    .bin  (b_rptr)
  );

  // A negative pointer difference means the write pointer has wrapped past the read pointer.
  always_comb begin
    accept      = wen && !full;
    next_b_wptr = b_wptr;
    next_waddr  = waddr;
    if (accept) begin
      next_b_wptr = (b_wptr == LAST) ? FIRST : b_wptr + 1'b1;
      next_waddr  = (waddr == ADDR_LAST) ? '0 : waddr + 1'b1;
    end
    diff        = {1'b0, next_b_wptr} - {1'b0, b_rptr};
    level_wide  = diff[PW] ? diff + SPAN : diff;
    wlevel_next = LW'(level_wide);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      b_wptr      <= FIRST;
      g_wptr      <= FIRST_GRAY;
      waddr       <= '0;
      wlevel      <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      b_wptr      <= next_b_wptr;
      g_wptr      <= PW'(bin2gray(32'(next_b_wptr)));
      waddr       <= next_waddr;
      wlevel      <= wlevel_next;
      full        <= (wlevel_next == LVL_FULL);
      almost_full <= (wlevel_next >= afull_thresh);
    end
  end

  // A dropped write takes priority over a clear arriving in the same cycle.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      overflow <= 1'b0;
    end else if (wen && full) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

`ifndef SYNTHESIS
  logic [PW:0] rptr_rel;
  assign rptr_rel = {1'b0, b_rptr} - (PW + 1)'(OFFSET);

  a_gray_one_bit: assert property (@(posedge wclk) disable iff (!wrst_n)
    $onehot0(g_wptr ^ $past(g_wptr)));
  a_level_bound: assert property (@(posedge wclk) disable iff (!wrst_n)
    wlevel <= LVL_FULL);
  a_rptr_range: assert property (@(posedge wclk) disable iff (!wrst_n)
    rptr_rel < SPAN);
  a_full_level: assert property (@(posedge wclk) disable iff (!wrst_n)
    full == (wlevel == LVL_FULL));
`endif

endmodule

// File: tb/tb_w_ptr_ctrl.sv
// Randomised self-checking bench for w_ptr_ctrl at DEPTH=45 and DEPTH=8.
// Expected values come from plain write/read transaction counters, not from pointer codes.
`timescale 1ns/1ps
module tb_w_ptr_ctrl;

  logic wclk = 1'b0;
  logic wrst_n = 1'b0;
  always #5 wclk = ~wclk;

  // Index 0 is the DEPTH=45 instance, index 1 the DEPTH=8 instance.
  int     depth[2] = '{45, 8};
  int     offs[2]  = '{19, 0};
  bit     m_wen[2];
  bit     m_clr[2];
  int     m_thr[2];
  longint wcnt[2];
  longint rcnt[2];
  bit     m_full[2];
  bit     m_afull[2];
  bit     m_ovf[2];
  int     compared = 0;
  int     mismatched = 0;

  logic       wen0, clr0, full0, afull0, ovf0;
  logic [6:0] g_rptr0, b_wptr0, g_wptr0;
  logic [5:0] thr0, waddr0, wlevel0;
  logic       wen1, clr1, full1, afull1, ovf1;
  logic [3:0] g_rptr1, b_wptr1, g_wptr1, thr1, wlevel1;
  logic [2:0] waddr1;

  w_ptr_ctrl #(.DEPTH(45)) dut45 (
    .wclk(wclk), .wrst_n(wrst_n), .wen(wen0), .g_rptr_sync(g_rptr0),
    .afull_thresh(thr0), .clr_ovf(clr0), .waddr(waddr0), .b_wptr(b_wptr0),
    .g_wptr(g_wptr0), .wlevel(wlevel0), .full(full0), .almost_full(afull0),
    .overflow(ovf0)
  );

  w_ptr_ctrl #(.DEPTH(8)) dut8 (
    .wclk(wclk), .wrst_n(wrst_n), .wen(wen1), .g_rptr_sync(g_rptr1),
    .afull_thresh(thr1), .clr_ovf(clr1), .waddr(waddr1), .b_wptr(b_wptr1),
    .g_wptr(g_wptr1), .wlevel(wlevel1), .full(full1), .almost_full(afull1),
    .overflow(ovf1)
  );

  function automatic int gray(input int b);
    return b ^ (b >> 1);
  endfunction

  function automatic int ptrCode(input int u, input longint n);
    return offs[u] + int'(n % longint'(2 * depth[u]));
  endfunction

  task automatic checkOutput(input string tag, input longint got, input longint exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic driveInputs();
    wen0    = m_wen[0];
    clr0    = m_clr[0];
    thr0    = 6'(m_thr[0]);
    g_rptr0 = 7'(gray(ptrCode(0, rcnt[0])));
    wen1    = m_wen[1];
    clr1    = m_clr[1];
    thr1    = 4'(m_thr[1]);
    g_rptr1 = 4'(gray(ptrCode(1, rcnt[1])));
  endtask

  task automatic resetModel();
    for (int u = 0; u < 2; u++) begin
      wcnt[u]    = 0;
      rcnt[u]    = 0;
      m_full[u]  = 1'b0;
      m_afull[u] = 1'b0;
      m_ovf[u]   = 1'b0;
      m_wen[u]   = 1'b0;
      m_clr[u]   = 1'b0;
    end
  endtask

  // Reads only retire data that has already been written.
  task automatic applyStimulus(input int u, input bit w, input bit radv, input bit clr);
    m_wen[u] = w;
    m_clr[u] = clr;
    if (radv && rcnt[u] < wcnt[u]) rcnt[u]++;
  endtask

  task automatic modelEdge(input int u);
    longint lvl;
    if (m_wen[u] && m_full[u]) m_ovf[u] = 1'b1;
    else if (m_clr[u])         m_ovf[u] = 1'b0;
    if (m_wen[u] && !m_full[u]) wcnt[u]++;
    lvl        = wcnt[u] - rcnt[u];
    m_full[u]  = (lvl == longint'(depth[u]));
    m_afull[u] = (lvl >= longint'(m_thr[u]));
  endtask

  task automatic compareAll(input int u);
    longint got[7];
    string  p;
    int     b;
    p = $sformatf("d%0d.", depth[u]);
    b = ptrCode(u, wcnt[u]);
    if (u == 0)
      got = '{longint'(b_wptr0), longint'(g_wptr0), longint'(waddr0), longint'(wlevel0),
              longint'(full0), longint'(afull0), longint'(ovf0)};
    else
      got = '{longint'(b_wptr1), longint'(g_wptr1), longint'(waddr1), longint'(wlevel1),
              longint'(full1), longint'(afull1), longint'(ovf1)};
    checkOutput({p, "b_wptr"}, got[0], longint'(b));
    checkOutput({p, "g_wptr"}, got[1], longint'(gray(b)));
    checkOutput({p, "waddr"}, got[2], wcnt[u] % longint'(depth[u]));
    checkOutput({p, "wlevel"}, got[3], wcnt[u] - rcnt[u]);
    checkOutput({p, "full"}, got[4], longint'(m_full[u]));
    checkOutput({p, "almost_full"}, got[5], longint'(m_afull[u]));
    checkOutput({p, "overflow"}, got[6], longint'(m_ovf[u]));
  endtask

  task automatic runCycle();
    driveInputs();
    @(posedge wclk);
    for (int u = 0; u < 2; u++) modelEdge(u);
    #1;
    for (int u = 0; u < 2; u++) compareAll(u);
    for (int u = 0; u < 2; u++) begin
      m_wen[u] = 1'b0;
      m_clr[u] = 1'b0;
    end
  endtask

  task automatic randomCycles(input int n);
    for (int i = 0; i < n; i++) begin
      for (int u = 0; u < 2; u++)
        applyStimulus(u, $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50,
                      $urandom_range(0, 99) < 5);
      runCycle();
    end
  endtask

  initial begin
    int  prev_b;
    int  prev_g;
    bit  wrap_seen;

    m_thr = '{40, 6};
    resetModel();
    driveInputs();
    repeat (2) @(posedge wclk);
    #1;
    compareAll(0);
    compareAll(1);
    checkOutput("rst.b_wptr", longint'(b_wptr0), 19);
    checkOutput("rst.g_wptr", longint'(g_wptr0), longint'(7'b0011010));
    @(negedge wclk);
    wrst_n = 1'b1;

    // Fill both instances from empty with the read pointer parked at its reset code.
    for (int i = 1; i <= 45; i++) begin
      applyStimulus(0, 1'b1, 1'b0, 1'b0);
      if (i <= 8) applyStimulus(1, 1'b1, 1'b0, 1'b0);
      runCycle();
      if (i == 39) checkOutput("afull.at39", longint'(afull0), 0);
      if (i == 40) checkOutput("afull.at40", longint'(afull0), 1);
      if (i == 8) begin
        checkOutput("d8.fill.full", longint'(full1), 1);
        checkOutput("d8.fill.b_wptr", longint'(b_wptr1), 8);
        checkOutput("d8.fill.waddr", longint'(waddr1), 0);
      end
    end
    checkOutput("fill.full", longint'(full0), 1);
    checkOutput("fill.b_wptr", longint'(b_wptr0), 64);
    checkOutput("fill.waddr", longint'(waddr0), 0);
    checkOutput("fill.wlevel", longint'(wlevel0), 45);

    applyStimulus(0, 1'b1, 1'b0, 1'b0);
    runCycle();
    checkOutput("ovf.b_wptr", longint'(b_wptr0), 64);
    checkOutput("ovf.set", longint'(ovf0), 1);
    applyStimulus(0, 1'b1, 1'b0, 1'b1);
    runCycle();
    checkOutput("ovf.set_wins", longint'(ovf0), 1);
    applyStimulus(0, 1'b0, 1'b0, 1'b1);
    runCycle();
    checkOutput("ovf.clear", longint'(ovf0), 0);

    repeat (5) begin
      applyStimulus(0, 1'b0, 1'b1, 1'b0);
      runCycle();
    end
    checkOutput("afull.at40_read", longint'(afull0), 1);
    applyStimulus(0, 1'b0, 1'b1, 1'b0);
    runCycle();
    checkOutput("afull.drop", longint'(afull0), 0);

    repeat (29) begin
      applyStimulus(0, 1'b0, 1'b1, 1'b0);
      runCycle();
    end

    // Stream with the reader ten entries behind, across the pointer wrap.
    wrap_seen = 1'b0;
    prev_b = int'(b_wptr0);
    prev_g = int'(g_wptr0);
    for (int i = 0; i < 100; i++) begin
      applyStimulus(0, 1'b1, 1'b1, 1'b0);
      runCycle();
      checkOutput("wrap.wlevel", longint'(wlevel0), 10);
      if (prev_b == 108) begin
        wrap_seen = 1'b1;
        checkOutput("wrap.b_wptr", longint'(b_wptr0), 19);
        checkOutput("wrap.g_before", longint'(prev_g), longint'(7'b1011010));
        checkOutput("wrap.g_after", longint'(g_wptr0), longint'(7'b0011010));
      end
      prev_b = int'(b_wptr0);
      prev_g = int'(g_wptr0);
    end
    checkOutput("wrap.seen", longint'(wrap_seen), 1);

    m_thr[0] = int'($urandom_range(0, 45));
    m_thr[1] = int'($urandom_range(0, 8));
    randomCycles(3000);

    // Asynchronous reset between clock edges, then resume random traffic.
    #2;
    wrst_n = 1'b0;
    #1;
    resetModel();
    compareAll(0);
    compareAll(1);
    driveInputs();
    @(posedge wclk);
    @(negedge wclk);
    wrst_n = 1'b1;
    randomCycles(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
